// File: rtl/l2_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_arbiter_if : I-cache / D-cache / L2 line-transfer bundle.  Rev 1.0
// ---------------------------------------------------------------------------
interface l2_arbiter_if #(
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 16
);
    logic              icache_read;
    logic [ADDR_W-1:0] icache_addr;
    logic [WIDTH-1:0]  icache_rdata;
    logic              icache_resp;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_addr;
    logic [WIDTH-1:0]  dcache_wdata;
    logic [WIDTH-1:0]  dcache_rdata;
    logic              dcache_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [WIDTH-1:0]  l2_wdata;
    logic [WIDTH-1:0]  l2_rdata;
    logic              l2_resp;

    modport slave (
        input  icache_read, icache_addr, dcache_read, dcache_write, dcache_addr,
               dcache_wdata, l2_rdata, l2_resp,
        output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
               l2_read, l2_write, l2_addr, l2_wdata
    );

    modport master (
        output icache_read, icache_addr, dcache_read, dcache_write, dcache_addr,
               dcache_wdata, l2_rdata, l2_resp,
        input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
               l2_read, l2_write, l2_addr, l2_wdata
    );
endinterface
`default_nettype wire

// File: rtl/l2_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_arbiter : round-robin owner of the shared L2 port for I/D line misses.
// Rev 1.0
// ---------------------------------------------------------------------------
module l2_arbiter #(
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    l2_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_I = 2'd1;
    localparam logic [1:0] S_GRANT_D = 2'd2;

    logic [1:0]        r_state;
    logic              r_last_d;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;

    logic w_i_req;
    logic w_d_req;
    logic w_pick_i;
    logic w_pick_d;
    logic w_busy;

    assign w_i_req  = bus.icache_read;
    assign w_d_req  = bus.dcache_read | bus.dcache_write;
    // On a tie the side that did not win last time goes first.
    assign w_pick_i = w_i_req & (~w_d_req | r_last_d);
    assign w_pick_d = w_d_req & ~w_pick_i;
    assign w_busy   = (r_state == S_GRANT_I) || (r_state == S_GRANT_D);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_last_d <= 1'b1;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_i) begin
                        r_state <= S_GRANT_I;
                        r_addr  <= bus.icache_addr;
                        r_write <= 1'b0;
                        r_wdata <= bus.dcache_wdata;
                    end else if (w_pick_d) begin
                        r_state <= S_GRANT_D;
                        r_addr  <= bus.dcache_addr;
                        r_write <= bus.dcache_write;
                        r_wdata <= bus.dcache_wdata;
                    end
                end
                S_GRANT_I: begin
                    if (bus.l2_resp) begin
                        r_state  <= S_IDLE;
                        r_last_d <= 1'b0;
                    end
                end
                S_GRANT_D: begin
                    if (bus.l2_resp) begin
                        r_state  <= S_IDLE;
                        r_last_d <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A transaction caught by reset is abandoned, so no completion escapes.
    assign bus.icache_resp  = (r_state == S_GRANT_I) & bus.l2_resp & rst_n;
    assign bus.dcache_resp  = (r_state == S_GRANT_D) & bus.l2_resp & rst_n;
    assign bus.icache_rdata = bus.l2_rdata;
    assign bus.dcache_rdata = bus.l2_rdata;
    assign bus.l2_read      = w_busy & ~r_write;
    assign bus.l2_write     = w_busy & r_write;
    assign bus.l2_addr      = r_addr;
    assign bus.l2_wdata     = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_l2_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_l2_arbiter : scoreboard bench; the bench plays both requesters and the L2.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_l2_arbiter;
    localparam int WIDTH  = 256;
    localparam int ADDR_W = 16;

    typedef struct {
        bit                is_d;
        bit                write;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  wdata;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    l2_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    l2_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_i(input logic [ADDR_W-1:0] addr);
        exp_t e;
        bus.icache_read = 1'b1;
        bus.icache_addr = addr;
        e.is_d = 1'b0; e.write = 1'b0; e.addr = addr; e.wdata = '0;
        sb.push_back(e);
    endtask

    task automatic push_d(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                          input logic [WIDTH-1:0] wdata);
        exp_t e;
        bus.dcache_read  = rd;
        bus.dcache_write = wr;
        bus.dcache_addr  = addr;
        bus.dcache_wdata = wdata;
        e.is_d = 1'b1; e.write = wr; e.addr = addr; e.wdata = wdata;
        sb.push_back(e);
    endtask

    // Acts as the L2: waits for a grant, checks it against the scoreboard head,
    // holds it for lat cycles, answers, then checks the mandatory idle cycle.
    task automatic serve(input int lat, input logic [WIDTH-1:0] rd, input bit drop,
                         input bit mutate);
        exp_t e;
        int   t;
        t = 0;
        @(posedge clk);
        @(negedge clk);
        while (!(bus.l2_read || bus.l2_write) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            check("grant_timeout", 1'b0, 1'b1);
            return;
        end
        check("grant_latency", t, 0);
        if (sb.size() == 0) begin
            check("unexpected_grant", 1'b1, 1'b0);
            return;
        end
        e = sb.pop_front();
        check("l2_addr", bus.l2_addr, e.addr);
        check("l2_op", {bus.l2_read, bus.l2_write}, e.write ? 2'b01 : 2'b10);
        if (e.write) check("l2_wdata", bus.l2_wdata, e.wdata);
        for (int k = 0; k < lat; k++) begin
            @(posedge clk);
            #1;
            if (mutate && k == 0) begin
                bus.dcache_wdata = {WIDTH{1'b1}};
                bus.dcache_addr  = 16'hFFFF;
            end
            @(negedge clk);
            check("op_held", {bus.l2_read, bus.l2_write}, e.write ? 2'b01 : 2'b10);
            check("addr_held", bus.l2_addr, e.addr);
            if (e.write) check("wdata_held", bus.l2_wdata, e.wdata);
            check("no_early_resp", {bus.icache_resp, bus.dcache_resp}, 2'b00);
        end
        @(posedge clk);
        #1;
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = rd;
        @(negedge clk);
        check("icache_resp", bus.icache_resp, !e.is_d);
        check("dcache_resp", bus.dcache_resp, e.is_d);
        check("rdata", e.is_d ? bus.dcache_rdata : bus.icache_rdata, rd);
        @(posedge clk);
        #1;
        bus.l2_resp = 1'b0;
        if (drop) begin
            if (e.is_d) begin
                bus.dcache_read  = 1'b0;
                bus.dcache_write = 1'b0;
            end else begin
                bus.icache_read = 1'b0;
            end
        end
        @(negedge clk);
        check("idle_gap", {bus.l2_read, bus.l2_write}, 2'b00);
        check("resp_pulse", {bus.icache_resp, bus.dcache_resp}, 2'b00);
    endtask

    initial begin
        bus.icache_read  = 1'b0;
        bus.icache_addr  = '0;
        bus.dcache_read  = 1'b0;
        bus.dcache_write = 1'b0;
        bus.dcache_addr  = '0;
        bus.dcache_wdata = '0;
        bus.l2_rdata     = '0;
        bus.l2_resp      = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {bus.l2_read, bus.l2_write}, 2'b00);
        check("rst_resps", {bus.icache_resp, bus.dcache_resp}, 2'b00);
        check("rst_addr", bus.l2_addr, 16'h0);
        check("rst_wdata", bus.l2_wdata, 256'h0);

        // Stray L2 response while idle
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = {32{8'h3C}};
        @(negedge clk);
        check("stray_resps", {bus.icache_resp, bus.dcache_resp}, 2'b00);
        @(posedge clk);
        #1;
        bus.l2_resp = 1'b0;
        @(negedge clk);
        check("stray_strobes", {bus.l2_read, bus.l2_write}, 2'b00);
        check("stray_resps2", {bus.icache_resp, bus.dcache_resp}, 2'b00);

        // Tie after reset: I first, then D
        @(posedge clk);
        #1;
        push_i(16'h1111);
        push_d(1'b1, 1'b0, 16'h2222, {64{4'h7}});
        serve(3, {32{8'h11}}, 1'b1, 1'b0);
        serve(2, {32{8'h22}}, 1'b1, 1'b0);

        // Lone I-cache read answered four cycles after the request
        @(posedge clk);
        #1;
        push_i(16'h1230);
        serve(2, {32{8'hA5}}, 1'b1, 1'b0);

        // Reset while D owns the L2 (last winner is I here)
        @(posedge clk);
        #1;
        bus.dcache_write = 1'b1;
        bus.dcache_addr  = 16'h7000;
        bus.dcache_wdata = {64{4'hC}};
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_grant", {bus.l2_read, bus.l2_write}, 2'b01);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        bus.l2_resp = 1'b1;
        @(negedge clk);
        check("rst_mid_noresp", {bus.icache_resp, bus.dcache_resp}, 2'b00);
        @(posedge clk);
        #1;
        rst_n            = 1'b1;
        bus.l2_resp      = 1'b0;
        bus.dcache_write = 1'b0;
        @(negedge clk);
        check("rst_mid_strobes", {bus.l2_read, bus.l2_write}, 2'b00);
        check("rst_mid_addr", bus.l2_addr, 16'h0);
        @(posedge clk);
        #1;
        push_i(16'h0A0A);
        push_d(1'b1, 1'b0, 16'h0B0B, '0);
        serve(1, {32{8'h5A}}, 1'b1, 1'b0);
        serve(1, {32{8'h6B}}, 1'b1, 1'b0);

        // Continuous contention: I, D, I, D
        @(posedge clk);
        #1;
        push_i(16'h3001);
        push_d(1'b1, 1'b0, 16'h3002, '0);
        push_i(16'h3001);
        push_d(1'b1, 1'b0, 16'h3002, '0);
        serve(1, {16{16'h0101}}, 1'b0, 1'b0);
        serve(2, {16{16'h0202}}, 1'b0, 1'b0);
        serve(0, {16{16'h0303}}, 1'b1, 1'b0);
        serve(1, {16{16'h0404}}, 1'b1, 1'b0);

        // D write-back with requester inputs scrambled after grant
        @(posedge clk);
        #1;
        push_d(1'b0, 1'b1, 16'h4000, {64{4'h5}});
        serve(3, {32{8'hEE}}, 1'b1, 1'b1);

        // Read and write asserted together behave as a write
        @(posedge clk);
        #1;
        push_d(1'b1, 1'b1, 16'h5555, {32{8'h96}});
        serve(1, {32{8'h69}}, 1'b1, 1'b0);

        if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
